// File: rtl/ahb_master_if_if.sv
// Bundle of command, response and AHB-Lite signals for the single-master
// transfer engine. The master modport is the engine's view, the slave
// modport is the view of whatever drives commands and models the bus.
interface ahb_master_if_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_size;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [1:0]        sel;
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready;
   logic              hresp;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
      input  hrdata, hready, hresp,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output sel, haddr, htrans, hwrite, hsize, hburst, hwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
      output hrdata, hready, hresp,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  sel, haddr, htrans, hwrite, hsize, hburst, hwdata
   );
endinterface

// File: rtl/ahb_master_if.sv
// Single-master AHB-Lite transfer engine: accepts one valid/ready command at
// a time, runs it as a SINGLE NONSEQ transfer and reports completion on a
// one-cycle response strobe. All outputs come straight from registers.
module ahb_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic           hclk,
   input logic           hreset,
   ahb_master_if_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [ADDR_W-1:0] r_haddr;
   logic [1:0]        r_htrans;
   logic              r_hwrite;
   logic [2:0]        r_hsize;
   logic [DATA_W-1:0] r_hwdata;
   logic [DATA_W-1:0] r_wdata;

   // Transfer FSM: address and control are latched at accept and held until
   // the next accept, so the decoder select stays stable through the data
   // phase and beyond; only htrans marks a live address phase.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_haddr     <= '0;
         r_htrans    <= HTRANS_IDLE;
         r_hwrite    <= 1'b0;
         r_hsize     <= 3'b010;
         r_hwdata    <= '0;
         r_wdata     <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_haddr     <= bus.cmd_addr;
                  r_hwrite    <= bus.cmd_write;
                  r_hsize     <= bus.cmd_size;
                  r_wdata     <= bus.cmd_wdata;
                  r_htrans    <= HTRANS_NONSEQ;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.hready) begin
                  r_htrans <= HTRANS_IDLE;
                  r_hwdata <= r_wdata;
                  r_state  <= S_DATA;
               end
            end
            S_DATA: begin
               // An ERROR response is waited through like any wait state and
               // only its final (hready=1) cycle is sampled.
               if (bus.hready) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= bus.hresp;
                  if (!r_hwrite) begin
                     r_rsp_rdata <= bus.hrdata;
                  end
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_htrans    <= HTRANS_IDLE;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.haddr     = r_haddr;
   assign bus.sel       = r_haddr[ADDR_W-1 -: 2];
   assign bus.htrans    = r_htrans;
   assign bus.hwrite    = r_hwrite;
   assign bus.hsize     = r_hsize;
   assign bus.hburst    = 3'b000;
   assign bus.hwdata    = r_hwdata;

endmodule

// File: tb/tb_ahb_master_if.sv
// Self-checking bench for ahb_master_if: a transaction-level model predicts
// every output each cycle from the commands and bus handshakes driven.
module tb_ahb_master_if;
   localparam int AW = 32;
   localparam int DW = 32;

   logic hclk   = 1'b0;
   logic hreset = 1'b1;
   always #5 hclk = ~hclk;

   ahb_master_if_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ahb_master_if #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;
   int txn_count = 0;

   // Model: one outstanding command plus the number of hready-high edges it
   // has seen since being accepted (0: address phase, 1: data phase).
   bit          m_busy;
   int          m_edges;
   logic [31:0] m_addr;
   logic        m_write;
   logic [2:0]  m_size;
   logic [31:0] m_wdata;
   logic [31:0] m_hwdata;
   logic [31:0] m_rdata;
   logic        m_rsp_valid;
   logic        m_rsp_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy      = 1'b0;
      m_edges     = 0;
      m_addr      = '0;
      m_write     = 1'b0;
      m_size      = 3'b010;
      m_wdata     = '0;
      m_hwdata    = '0;
      m_rdata     = '0;
      m_rsp_valid = 1'b0;
      m_rsp_err   = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs now driven.
   task automatic model_advance();
      logic nv;
      nv = 1'b0;
      if (!m_busy) begin
         if (bus.cmd_valid) begin
            m_busy  = 1'b1;
            m_edges = 0;
            m_addr  = bus.cmd_addr;
            m_write = bus.cmd_write;
            m_size  = bus.cmd_size;
            m_wdata = bus.cmd_wdata;
         end
      end else if (bus.hready) begin
         m_edges++;
         if (m_edges == 1) begin
            m_hwdata = m_wdata;
         end else begin
            nv        = 1'b1;
            m_busy    = 1'b0;
            m_rsp_err = bus.hresp;
            if (!m_write) m_rdata = bus.hrdata;
            txn_count++;
            $display("txn %0d: %s addr=%08h size=%0d wdata=%08h rdata=%08h err=%0d",
                     txn_count, m_write ? "WR" : "RD", m_addr, m_size, m_wdata,
                     m_write ? 32'h0 : bus.hrdata, bus.hresp);
         end
      end
      m_rsp_valid = nv;
   endtask

   task automatic compare_all();
      logic [1:0] exp_trans;
      exp_trans = (m_busy && m_edges == 0) ? 2'b10 : 2'b00;
      check("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy));
      check("htrans",    64'(bus.htrans),    64'(exp_trans));
      check("haddr",     64'(bus.haddr),     64'(m_addr));
      check("sel",       64'(bus.sel),       64'(m_addr[31:30]));
      check("hwrite",    64'(bus.hwrite),    64'(m_write));
      check("hsize",     64'(bus.hsize),     64'(m_size));
      check("hburst",    64'(bus.hburst),    64'(3'b000));
      check("hwdata",    64'(bus.hwdata),    64'(m_hwdata));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_valid));
      check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rdata));
      if (m_rsp_valid) check("rsp_err", 64'(bus.rsp_err), 64'(m_rsp_err));
   endtask

   // Drive one cycle of inputs (called at a falling edge), then compare after
   // the next rising edge at the following falling edge.
   task automatic step(input logic v, input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input logic rdy, input logic resp, input logic [31:0] rd);
      bus.cmd_valid = v;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_size  = sz;
      bus.cmd_wdata = wd;
      bus.hready    = rdy;
      bus.hresp     = resp;
      bus.hrdata    = rd;
      model_advance();
      @(negedge hclk);
      compare_all();
   endtask

   task automatic idle(input logic rdy, input logic resp, input logic [31:0] rd);
      step(1'b0, 1'($urandom % 2), $urandom, 3'($urandom % 8), $urandom, rdy, resp, rd);
   endtask

   initial begin
      logic [1:0]  seen_sel[$];
      int          seen_cyc[$];
      int          acc;
      int          cyc;
      logic [31:0] a;
      bit          will_accept;

      model_reset();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_size  = 3'b010;
      bus.cmd_wdata = '0;
      bus.hready    = 1'b1;
      bus.hresp     = 1'b0;
      bus.hrdata    = '0;

      // Reset state
      repeat (2) @(negedge hclk);
      compare_all();
      check("reset hsize", 64'(bus.hsize), 64'(3'b010));
      check("reset cmd_ready", 64'(bus.cmd_ready), 64'(1));
      hreset = 1'b0;
      idle(1'b1, 1'b0, 32'h0);

      // Zero-wait write
      step(1'b1, 1'b1, 32'h4000_0010, 3'b010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      check("zw c1 htrans", 64'(bus.htrans), 64'(2'b10));
      check("zw c1 sel",    64'(bus.sel),    64'(2'b01));
      check("zw c1 hwrite", 64'(bus.hwrite), 64'(1));
      idle(1'b1, 1'b0, 32'h0);
      check("zw c2 hwdata", 64'(bus.hwdata), 64'(32'hDEAD_BEEF));
      check("zw c2 htrans", 64'(bus.htrans), 64'(2'b00));
      idle(1'b1, 1'b0, 32'h0);
      check("zw c3 rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("zw c3 rsp_err",   64'(bus.rsp_err),   64'(0));
      idle(1'b1, 1'b0, 32'h0);

      // Read with two data-phase wait states
      step(1'b1, 1'b0, 32'hC000_0000, 3'b010, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'hFFFF_FFFF);
      check("rd c2 sel", 64'(bus.sel), 64'(2'b11));
      idle(1'b0, 1'b0, 32'hAAAA_AAAA);
      check("rd c3 sel", 64'(bus.sel), 64'(2'b11));
      idle(1'b0, 1'b0, 32'h5555_5555);
      check("rd c4 rsp_valid", 64'(bus.rsp_valid), 64'(0));
      idle(1'b1, 1'b0, 32'h1234_5678);
      check("rd c5 rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("rd c5 rsp_rdata", 64'(bus.rsp_rdata), 64'(32'h1234_5678));
      idle(1'b1, 1'b0, 32'h0);

      // Two-cycle ERROR response, then a clean command
      step(1'b1, 1'b1, 32'h8000_0100, 3'b010, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'h0);
      idle(1'b0, 1'b1, 32'h0);
      idle(1'b1, 1'b1, 32'h0);
      check("err rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("err rsp_err",   64'(bus.rsp_err),   64'(1));
      step(1'b1, 1'b0, 32'h0000_0020, 3'b001, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'h7777_0001);
      check("after err rsp_err", 64'(bus.rsp_err), 64'(0));
      check("after err rdata",   64'(bus.rsp_rdata), 64'(32'h7777_0001));

      // Busy / back-to-back with cmd_valid held and commands changing each cycle
      acc = 0;
      cyc = 0;
      for (int c = 0; c < 40 && acc < 4; c++) begin
         a = {acc[1:0], 30'($urandom & 32'h3FFF_FFFC)};
         will_accept = !m_busy;
         step(1'b1, 1'($urandom % 2), a, 3'b010, $urandom, 1'b1, 1'b0, $urandom);
         if (will_accept) acc++;
         cyc++;
         if (bus.htrans == 2'b10) begin
            seen_sel.push_back(bus.sel);
            seen_cyc.push_back(cyc);
         end
      end
      check("b2b accepted", 64'(acc), 64'(4));
      check("b2b nonseq count", 64'(seen_sel.size()), 64'(4));
      for (int i = 0; i < seen_sel.size(); i++) begin
         check("b2b sel order", 64'(seen_sel[i]), 64'(i));
         if (i > 0) check("b2b spacing", 64'(seen_cyc[i] - seen_cyc[i-1]), 64'(3));
      end
      repeat (3) idle(1'b1, 1'b0, $urandom);

      // Reset in the middle of a waited data phase
      step(1'b1, 1'b0, 32'h8000_0040, 3'b010, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'h0);
      idle(1'b0, 1'b0, 32'h0);
      bus.hready = 1'b0;
      #2 hreset = 1'b1;
      #1;
      check("mid rst htrans",    64'(bus.htrans),    64'(0));
      check("mid rst cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("mid rst rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("mid rst haddr",     64'(bus.haddr),     64'(0));
      check("mid rst hwdata",    64'(bus.hwdata),    64'(0));
      check("mid rst hsize",     64'(bus.hsize),     64'(3'b010));
      model_reset();
      @(negedge hclk);
      compare_all();
      hreset = 1'b0;
      idle(1'b1, 1'b0, $urandom);
      idle(1'b1, 1'b0, $urandom);
      step(1'b1, 1'b0, 32'h4000_0004, 3'b010, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'h0);
      idle(1'b1, 1'b0, 32'hCAFE_0042);
      check("post rst rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("post rst rdata",     64'(bus.rsp_rdata), 64'(32'hCAFE_0042));

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         step(1'(($urandom % 3) != 0), 1'($urandom % 2), $urandom, 3'($urandom % 3),
              $urandom, 1'(($urandom % 4) != 0), 1'(($urandom % 4) == 0), $urandom);
      end
      repeat (4) idle(1'b1, 1'b0, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ahb_master_if.md
# ahb_master_if

Single-master AHB-Lite transfer engine that turns a simple valid/ready command interface into single AHB transfers and returns read data and error status on a one-cycle response strobe. It sits directly upstream of the 4-slave address decoder. It drives the decoder's 2-bit `sel` input from the top two address bits and holds `sel` stable through the data phase, so downstream read-data muxing stays valid.

## Interface
- `ADDR_W`, default 32: address width, minimum 3.
- `DATA_W`, default 32: data width, 8/16/32.
- `hclk` in 1: clock, all state on rising edge.
- `hreset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: engine can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: byte address.
- `cmd_size` in 3: HSIZE encoding, passed through.
- `cmd_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_rdata` out DATA_W: read data, valid with `rsp_valid` for reads; holds last value otherwise.
- `rsp_err` out 1: slave returned ERROR, valid with `rsp_valid`.
- `sel` out 2: slave select to the decoder, equal to `haddr[ADDR_W-1:ADDR_W-2]`.
- `haddr` out ADDR_W: AHB address.
- `htrans` out 2: IDLE=2'b00, NONSEQ=2'b10 only.
- `hwrite` out 1: AHB write.
- `hsize` out 3: AHB size.
- `hburst` out 3: constant 3'b000 (SINGLE).
- `hwdata` out DATA_W: AHB write data, data phase.
- `hrdata` in DATA_W: slave read data, muxed downstream.
- `hready` in 1: transfer done / bus ready.
- `hresp` in 1: 0 = OKAY, 1 = ERROR.

## Operation
- **FSM states:** IDLE, ADDR, DATA.
- **IDLE:**
  - `cmd_ready`=1 and `htrans`=IDLE.
  - On `cmd_valid`&`cmd_ready`, register write, addr, size and wdata, then go to ADDR.
- **ADDR:**
  - Drive `htrans`=NONSEQ with `haddr`, `hwrite`, `hsize` and `sel` from the registered command.
  - At the edge with `hready`=1, the address phase is complete and the FSM goes to DATA.
  - While `hready`=0, hold all address-phase outputs unchanged.
- **DATA:**
  - `htrans`=IDLE. `haddr`, `hwrite`, `hsize` and `sel` hold their ADDR values.
  - `hwdata` = registered wdata, driven for the whole data phase. Outside DATA it holds its last value.
  - Wait while `hready`=0. A two-cycle ERROR (`hresp`=1 with `hready`=0, then `hresp`=1 with `hready`=1) is simply waited through.
  - At the edge with `hready`=1:
    - capture `rsp_err` <= `hresp`;
    - capture `rsp_rdata` <= `hrdata` on reads only;
    - assert `rsp_valid` for the next cycle and return to IDLE.
- **Command handling:**
  - `cmd_ready`=0 in ADDR and DATA; commands are neither accepted nor buffered.
  - The command interface is not pipelined: one outstanding transfer at most.
- **`sel` / `haddr` after completion:** both hold the last transfer's values in IDLE, which keeps the decoder output stable. Only `htrans` marks validity.
- **Response failures:** an error response does not retry and does not block later commands.
- **`cmd_*` changes:** changes to `cmd_*` while not accepted have no effect.

## Timing
- **Reset values:**
  - state=IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_err`=0;
  - `rsp_rdata`=0, `sel`=2'b00, `haddr`=0, `htrans`=2'b00;
  - `hwrite`=0, `hsize`=3'b010, `hburst`=0, `hwdata`=0.
- **Zero-wait transfer:**
  - accept at edge 0;
  - address phase on bus in cycle 1, sampled at edge 1;
  - data phase in cycle 2, sampled at edge 2;
  - `rsp_valid`=1 in cycle 3.
  - Total: 3 cycles from accept to response; each wait state adds 1.
- **Back-to-back commands:** `cmd_ready` is 1 in the `rsp_valid` cycle, so a new command can be accepted there. Minimum issue interval is 3 cycles.
- **Outputs:** all outputs are registered; no combinational path from `hready`, `hresp` or `hrdata` to any output.
- **Reset mid-transfer:** `hreset` asserted in any state forces reset values immediately. The transfer is abandoned with no `rsp_valid`.

## Test plan
- **Reset:** assert `hreset` mid-cycle -> all outputs at listed reset values immediately; `cmd_ready`=1.
- **Zero-wait write:** write addr 0x4000_0010, data 0xDEAD_BEEF, `hready`=1 throughout:
  - cycle 1: `htrans`=2'b10, `sel`=2'b01, `hwrite`=1;
  - cycle 2: `hwdata`=0xDEAD_BEEF, `htrans`=0;
  - cycle 3: `rsp_valid`=1, `rsp_err`=0.
- **Read with wait states:** read addr 0xC000_0000 with `hready`=0 for 2 data-phase cycles, `hrdata`=0x1234_5678 on the completing cycle -> `sel`=2'b11 held through the data phase; `rsp_valid` in cycle 5 with `rsp_rdata`=0x1234_5678.
- **Error response:** data phase returns `hresp`=1/`hready`=0, then `hresp`=1/`hready`=1 -> `rsp_valid`=1 with `rsp_err`=1. Next command completes with `rsp_err`=0.
- **Busy / back-to-back:** hold `cmd_valid`=1 with new commands every cycle -> only accepted when `cmd_ready`=1. Four transfers to 0x0…, 0x4…, 0x8…, 0xC… produce `sel` 0,1,2,3 in order at a 3-cycle spacing.
- **Reset mid-transfer:** assert `hreset` during DATA with `hready`=0 -> no `rsp_valid`, `htrans`=0, state=IDLE. After release, the next command completes normally.
